stream_parity_acc: RTL and testbench
====================================

// Module: stream_parity_acc
// PURPOSE
//  Streaming successor of the combinational XOR reducer. Reduces each W-bit word to one
//  parity bit and accumulates it over a frame of up to MAXLEN words, with even/odd mode
//  and optional check against an expected bit. Frame result goes out on a valid/ready port.
//  Sits between a word source (UART/FIFO) and a status register or checker in the MCS I/O.
// PARAMETERS
//  W       32  data word width, >=1
//  MAXLEN  16  max words per frame, >=1; CW = $clog2(MAXLEN+1)
// PORTS
//  clk         in   1    system clock, all logic rising-edge
//  reset_n     in   1    asynchronous active-low reset
//  s_valid     in   1    input word valid
//  s_ready     out  1    block can accept a word
//  s_data      in   W    input word
//  s_last      in   1    current word closes the frame
//  odd         in   1    1 = odd parity, 0 = even; sampled on first beat of frame
//  chk_en      in   1    compare result to chk_bit; sampled on last beat
//  chk_bit     in   1    expected parity bit; sampled on last beat
//  m_valid     out  1    frame result valid
//  m_ready     in   1    downstream accepts result
//  m_parity    out  1    frame parity bit
//  m_count     out  CW   words in frame, saturates at MAXLEN
//  m_err       out  1    frame held more than MAXLEN words
//  m_mismatch  out  1    chk_en latched and m_parity != latched chk_bit
// BEHAVIOUR
//  - Clock and reset: single clock. reset_n low asynchronously forces state=ACC, acc=0,
//    cnt=0, err=0, first=1. All m_* = 0, s_ready = 0 while reset_n is low.
//  - Handshake: beat on s_valid & s_ready; result transfer on m_valid & m_ready.
//    m_* fields are stable while m_valid=1 and m_ready=0.
//  - Word reduction: per beat, wp = ^s_data (XOR of all W bits, combinational).
//  - ACC state: s_ready=1, m_valid=0. On each beat:
//      acc <= acc ^ wp; first <= 0.
//      cnt <= (cnt==MAXLEN) ? MAXLEN : cnt+1.
//      err <= err | (cnt==MAXLEN).
//      On a beat with first=1, odd is latched into odd_q.
//      On a beat with s_last=1: latch chk_en/chk_bit, register results, go to HOLD.
//  - Result (registered on the last beat):
//      m_parity = acc_next ^ odd_q_eff, where odd_q_eff = odd when the frame is one word.
//      m_count = cnt_next.
//      m_err = err_next.
//      m_mismatch = chk_en & (m_parity != chk_bit).
//  - Latency: m_valid rises the cycle after the last beat is accepted.
//  - HOLD state: m_valid=1, s_ready=0. On m_ready, go to ACC, clear acc/cnt/err, set first=1.
//    s_ready returns 1 the cycle after the transfer. This costs a one-cycle bubble per frame.
//  - Single-word frame (first=1 and s_last=1 on the same beat): legal, m_count=1.
//  - Frame longer than MAXLEN: accumulation continues over all words, count saturates,
//    m_err=1 in the result.
//  - s_valid=0 in ACC: state is held. No timeout.
//  - odd/chk inputs outside their sampling beats are ignored.
//  - Reset mid-frame or mid-HOLD: the partial frame or pending result is discarded.
//    No output is produced for it.
// TESTING
//  1 even: words 0x1,0x3,0x7(last), odd=0 -> 1 cyc after last: m_parity=0, m_count=3,
//    m_err=0, m_mismatch=0
//  2 odd: same words, odd=1 on first beat; odd toggled on later beats -> m_parity=1;
//    later toggles have no effect
//  3 check: single word 0xFFFF_FFFE(last), chk_en=1, chk_bit=0 -> m_parity=1,
//    m_count=1, m_mismatch=1
//  4 overflow (MAXLEN=16): 18 words of 0x1, last on 18th -> m_parity=0, m_count=16, m_err=1
//  5 backpressure: m_ready=0 for 5 cycles after m_valid -> s_ready=0, m_* stable;
//    m_ready=1 -> next cycle s_ready=1; next frame starts from acc=0, cnt=0
//  6 reset: drop reset_n after 2 words of a frame -> m_valid=0, s_ready=0 asynchronously;
//    after release, frame 0x1(last) gives m_parity=1, m_count=1

Source files
------------

// File: rtl/stream_parity_acc_if.sv
// rtl/stream_parity_acc_if.sv - word stream in, frame parity result out
interface stream_parity_acc_if #(
  parameter int W      = 32,
  parameter int MAXLEN = 16,
  parameter int CW     = $clog2(MAXLEN + 1)
);
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          odd;
  logic          chk_en;
  logic          chk_bit;
  logic          m_valid;
  logic          m_ready;
  logic          m_parity;
  logic [CW-1:0] m_count;
  logic          m_err;
  logic          m_mismatch;

  modport slave (
    input  s_valid, s_data, s_last, odd, chk_en, chk_bit, m_ready,
    output s_ready, m_valid, m_parity, m_count, m_err, m_mismatch
  );

  modport master (
    output s_valid, s_data, s_last, odd, chk_en, chk_bit, m_ready,
    input  s_ready, m_valid, m_parity, m_count, m_err, m_mismatch
  );
endinterface

// File: rtl/stream_parity_acc.sv
// rtl/stream_parity_acc.sv - per-frame parity accumulator with even/odd mode and check
module stream_parity_acc #(
  parameter int W      = 32,
  parameter int MAXLEN = 16,
  parameter int CW     = $clog2(MAXLEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  stream_parity_acc_if.slave      bus
);
  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAXLEN);

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          first_q, first_d;
  logic          odd_q, odd_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] count_q, count_d;
  logic          merr_q, merr_d;
  logic          mism_q, mism_d;

  logic          wp, s_ready_w, beat;
  logic          acc_nx, err_nx, odd_eff, par_nx;
  logic [CW-1:0] cnt_nx;

  // s_ready is gated by reset_n so it reads 0 while reset is asserted
  assign s_ready_w = reset_n && (state_q == ACC);
  assign beat      = bus.s_valid && s_ready_w;
  assign wp        = ^bus.s_data;

  assign bus.s_ready    = s_ready_w;
  assign bus.m_valid    = (state_q == HOLD);
  assign bus.m_parity   = parity_q;
  assign bus.m_count    = count_q;
  assign bus.m_err      = merr_q;
  assign bus.m_mismatch = mism_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    first_d  = first_q;
    odd_d    = odd_q;
    parity_d = parity_q;
    count_d  = count_q;
    merr_d   = merr_q;
    mism_d   = mism_q;
    acc_nx   = acc_q ^ wp;
    cnt_nx   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    err_nx   = err_q | (cnt_q == CNT_MAX);
    odd_eff  = first_q ? bus.odd : odd_q;
    par_nx   = acc_nx ^ odd_eff;
    case (state_q)
      ACC: begin
        if (beat) begin
          acc_d   = acc_nx;
          cnt_d   = cnt_nx;
          err_d   = err_nx;
          first_d = 1'b0;
          if (first_q) odd_d = bus.odd;
          if (bus.s_last) begin
            parity_d = par_nx;
            count_d  = cnt_nx;
            merr_d   = err_nx;
            mism_d   = bus.chk_en & (par_nx != bus.chk_bit);
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d = ACC;
          acc_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ACC;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b1;
      odd_q    <= 1'b0;
      parity_q <= 1'b0;
      count_q  <= '0;
      merr_q   <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      first_q  <= first_d;
      odd_q    <= odd_d;
      parity_q <= parity_d;
      count_q  <= count_d;
      merr_q   <= merr_d;
      mism_q   <= mism_d;
    end
  end
endmodule

// File: tb/tb_stream_parity_acc.sv
// tb/tb_stream_parity_acc.sv - scoreboard bench for stream_parity_acc
module tb_stream_parity_acc;
  localparam int W      = 32;
  localparam int MAXLEN = 16;
  localparam int CW     = $clog2(MAXLEN + 1);

  typedef struct packed {
    logic          parity;
    logic [CW-1:0] count;
    logic          err;
    logic          mism;
  } res_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  res_t exp_q[$];

  stream_parity_acc_if #(.W(W), .MAXLEN(MAXLEN)) bus ();

  stream_parity_acc #(.W(W), .MAXLEN(MAXLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic p, input int c, input logic e, input logic m);
    res_t r;
    r.parity = p;
    r.count  = CW'(c);
    r.err    = e;
    r.mism   = m;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, input logic o,
                      input logic ce, input logic cb);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.odd     = o;
    bus.chk_en  = ce;
    bus.chk_bit = cb;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  // Monitor: every result transfer is compared against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result with empty scoreboard, required none");
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("m_parity",   32'(bus.m_parity),   32'(e.parity));
        check("m_count",    32'(bus.m_count),    32'(e.count));
        check("m_err",      32'(bus.m_err),      32'(e.err));
        check("m_mismatch", 32'(bus.m_mismatch), 32'(e.mism));
      end
    end
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset_n     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.odd     = 1'b0;
    bus.chk_en  = 1'b0;
    bus.chk_bit = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_count", 32'(bus.m_count), 32'd0);
    reset_n = 1'b1;

    // 1: even parity, three words
    push(1'b0, 3, 1'b0, 1'b0);
    send(32'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_m_valid", 32'(bus.m_valid), 32'd1);
    @(negedge clk);

    // 2: odd latched on first beat only
    push(1'b1, 3, 1'b0, 1'b0);
    send(32'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b0, 3, 1'b0, 1'b0);
    send(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h7, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: single word with check enabled
    push(1'b1, 1, 1'b0, 1'b1);
    send(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1, 1'b0, 1'b0);
    send(32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 1'b0);

    // 4: overflow past MAXLEN
    push(1'b0, 16, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) send(32'h1, (i == 17), 1'b0, 1'b0, 1'b0);

    // 5: backpressure holds the result and blocks input
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    push(1'b1, 1, 1'b0, 1'b0);
    send(32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s_ready",  32'(bus.s_ready),  32'd0);
      check("bp_m_parity", 32'(bus.m_parity), 32'd1);
      check("bp_m_count",  32'(bus.m_count),  32'd1);
    end
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_xfer_s_ready", 32'(bus.s_ready), 32'd1);
    check("post_xfer_m_valid", 32'(bus.m_valid), 32'd0);
    push(1'b0, 1, 1'b0, 1'b0);
    send(32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 6: asynchronous reset mid-frame discards the partial frame
    send(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("async_rst_m_valid", 32'(bus.m_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push(1'b1, 1, 1'b0, 1'b0);
    send(32'h1, 1'b1, 1'b0, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
